// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment lit codes and capture FSM state type
package seg7_pkg;

  localparam logic [6:0] LIT_0     = 7'h3F;
  localparam logic [6:0] LIT_1     = 7'h06;
  localparam logic [6:0] LIT_2     = 7'h5B;
  localparam logic [6:0] LIT_3     = 7'h4F;
  localparam logic [6:0] LIT_4     = 7'h66;
  localparam logic [6:0] LIT_5     = 7'h6D;
  localparam logic [6:0] LIT_6     = 7'h7D;
  localparam logic [6:0] LIT_7     = 7'h07;
  localparam logic [6:0] LIT_8     = 7'h7F;
  localparam logic [6:0] LIT_9     = 7'h6F;
  localparam logic [6:0] LIT_BLANK = 7'h00;

  typedef enum logic {
    WAIT_BOTH = 1'b0,
    PUBLISH   = 1'b1
  } cap_state_t;

  // ten*10 + one without a multiplier
  function automatic logic [6:0] bcd_pair_to_bin(input logic [3:0] ten, input logic [3:0] one);
    return ({3'd0, ten} << 3) + ({3'd0, ten} << 1) + {3'd0, one};
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational lit-segment to BCD decoder
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] lit,
  output logic       legal,
  output logic       blank,
  output logic [3:0] bcd
);

  always_comb begin
    legal = 1'b1;
    blank = 1'b0;
    bcd   = 4'd0;
    case (lit)
      LIT_0:     bcd = 4'd0;
      LIT_1:     bcd = 4'd1;
      LIT_2:     bcd = 4'd2;
      LIT_3:     bcd = 4'd3;
      LIT_4:     bcd = 4'd4;
      LIT_5:     bcd = 4'd5;
      LIT_6:     bcd = 4'd6;
      LIT_7:     bcd = 4'd7;
      LIT_8:     bcd = 4'd8;
      LIT_9:     bcd = 4'd9;
      LIT_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// rtl/seg_capture.sv - debounced capture of a two-digit multiplexed 7-segment display
module seg_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYC     = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] digit_seg,
  input  logic [1:0] digit_con,
  output logic [3:0] one,
  output logic [3:0] ten,
  output logic [6:0] binary,
  output logic       val_valid,
  output logic       changed,
  output logic       err
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYC);

  logic [6:0] lit;
  logic [8:0] sample, prev;
  logic [7:0] cnt, cnt_next;
  logic       accept, acc_one, acc_ten;
  logic       legal, blank;
  logic [3:0] bcd;
  logic [3:0] pend_one, pend_ten;
  logic       one_flag, ten_flag, one_flag_next, ten_flag_next;
  logic       publish_go;
  logic [6:0] bin_new;
  cap_state_t state, state_next;

  assign lit    = SEG_ACTIVE_LOW ? ~digit_seg[6:0] : digit_seg[6:0];
  assign sample = {digit_con, lit};

  seg7_to_bcd u_dec (
    .lit   (lit),
    .legal (legal),
    .blank (blank),
    .bcd   (bcd)
  );

  // Accept only on the transition into saturation so a held pattern fires once
  always_comb begin
    if (sample == prev)
      cnt_next = (cnt == STABLE) ? cnt : cnt + 8'd1;
    else
      cnt_next = 8'd1;
  end

  assign accept  = (cnt_next == STABLE) && (cnt != STABLE);
  assign acc_one = accept && (digit_con == 2'b01);
  assign acc_ten = accept && (digit_con == 2'b10);
  assign bin_new = bcd_pair_to_bin(pend_ten, pend_one);

  // An accept during PUBLISH wins over the flag clear
  always_comb begin
    one_flag_next = one_flag;
    ten_flag_next = ten_flag;
    if (state == PUBLISH) begin
      one_flag_next = 1'b0;
      ten_flag_next = 1'b0;
    end
    if (acc_one) one_flag_next = legal;
    if (acc_ten) ten_flag_next = legal || blank;
  end

  always_comb begin
    state_next = state;
    publish_go = 1'b0;
    case (state)
      WAIT_BOTH: begin
        if (one_flag && ten_flag) begin
          state_next = PUBLISH;
          publish_go = 1'b1;
        end
      end
      PUBLISH:   state_next = WAIT_BOTH;
      default:   state_next = WAIT_BOTH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) state <= WAIT_BOTH;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      prev      <= '0;
      cnt       <= '0;
      one_flag  <= 1'b0;
      ten_flag  <= 1'b0;
      pend_one  <= '0;
      pend_ten  <= '0;
      one       <= '0;
      ten       <= '0;
      binary    <= '0;
      val_valid <= 1'b0;
      changed   <= 1'b0;
      err       <= 1'b0;
    end else begin
      prev      <= sample;
      cnt       <= cnt_next;
      one_flag  <= one_flag_next;
      ten_flag  <= ten_flag_next;
      err       <= (acc_one && !legal) || (acc_ten && !(legal || blank));
      val_valid <= publish_go;
      changed   <= publish_go && (bin_new != binary);
      if (acc_one && legal)
        pend_one <= bcd;
      if (acc_ten && (legal || blank))
        pend_ten <= bcd;
      if (publish_go) begin
        one    <= pend_one;
        ten    <= pend_ten;
        binary <= bin_new;
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// tb/tb_seg_capture.sv - directed table-driven bench for seg_capture
module tb_seg_capture;

  logic       clk = 1'b0;
  logic       res;
  logic [7:0] digit_seg;
  logic [1:0] digit_con;
  logic [3:0] one, ten;
  logic [6:0] binary;
  logic       val_valid, changed, err;

  int checks = 0;
  int errors = 0;

  seg_capture #(.STABLE_CYC(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk       (clk),
    .res       (res),
    .digit_seg (digit_seg),
    .digit_con (digit_con),
    .one       (one),
    .ten       (ten),
    .binary    (binary),
    .val_valid (val_valid),
    .changed   (changed),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] con;
    logic [6:0] lit;
    int         cyc;
    int         vv_n;
    int         err_n;
    int         bin;
    int         one;
    int         ten;
    int         chg;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Hold one pattern for cyc cycles, recording pulses seen after each edge
  task automatic run_seg(input logic [1:0] con, input logic [6:0] lit, input int cyc,
                         output int vv_n, output int vv_idx, output int err_n,
                         output int err_idx, output int chg);
    vv_n = 0; vv_idx = -1; err_n = 0; err_idx = -1; chg = -1;
    digit_con = con;
    digit_seg = {1'b1, ~lit};
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk);
      #1;
      if (val_valid) begin
        vv_n++;
        vv_idx = i;
        chg = int'(changed);
      end
      if (err) begin
        err_n++;
        err_idx = i;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " one"}, int'(one), 0);
    chk({tag, " ten"}, int'(ten), 0);
    chk({tag, " binary"}, int'(binary), 0);
    chk({tag, " val_valid"}, int'(val_valid), 0);
    chk({tag, " changed"}, int'(changed), 0);
    chk({tag, " err"}, int'(err), 0);
  endtask

  initial begin
    int vv_n, vv_idx, err_n, err_idx, chg;

    //            con    lit    cyc vv err bin one ten chg
    tbl[0]  = '{2'b01, 7'h06,  6, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{2'b10, 7'h5B,  6, 1, 0, 21, 1, 2, 1};
    tbl[2]  = '{2'b01, 7'h06,  6, 0, 0, 21, 1, 2, 0};
    tbl[3]  = '{2'b10, 7'h5B,  6, 1, 0, 21, 1, 2, 0};
    tbl[4]  = '{2'b01, 7'h4F,  3, 0, 0, 21, 1, 2, 0};
    tbl[5]  = '{2'b00, 7'h00,  6, 0, 0, 21, 1, 2, 0};
    tbl[6]  = '{2'b01, 7'h7F, 20, 0, 0, 21, 1, 2, 0};
    tbl[7]  = '{2'b10, 7'h00,  6, 1, 0,  8, 8, 0, 1};
    tbl[8]  = '{2'b01, 7'h49,  6, 0, 1,  8, 8, 0, 0};
    tbl[9]  = '{2'b10, 7'h6D,  6, 0, 0,  8, 8, 0, 0};
    tbl[10] = '{2'b01, 7'h66,  6, 1, 0, 54, 4, 5, 1};
    tbl[11] = '{2'b11, 7'h06,  6, 0, 0, 54, 4, 5, 0};
    tbl[12] = '{2'b01, 7'h07,  6, 0, 0, 54, 4, 5, 0};

    res = 1'b1;
    digit_con = 2'b00;
    digit_seg = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    res = 1'b0;

    for (int r = 0; r < 13; r++) begin
      run_seg(tbl[r].con, tbl[r].lit, tbl[r].cyc, vv_n, vv_idx, err_n, err_idx, chg);
      chk($sformatf("row%0d val_valid count", r), vv_n, tbl[r].vv_n);
      chk($sformatf("row%0d err count", r), err_n, tbl[r].err_n);
      chk($sformatf("row%0d binary", r), int'(binary), tbl[r].bin);
      chk($sformatf("row%0d one", r), int'(one), tbl[r].one);
      chk($sformatf("row%0d ten", r), int'(ten), tbl[r].ten);
      if (tbl[r].vv_n == 1) begin
        chk($sformatf("row%0d val_valid latency", r), vv_idx, 4);
        chk($sformatf("row%0d changed", r), chg, tbl[r].chg);
      end
      if (tbl[r].err_n == 1)
        chk($sformatf("row%0d err latency", r), err_idx, 3);
    end

    // Pending ones digit from the last row is dropped by a mid-operation reset
    res = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("midreset edge1");
    @(posedge clk);
    #1;
    chk_zero("midreset edge2");
    res = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("post reset");

    run_seg(2'b10, 7'h6D, 10, vv_n, vv_idx, err_n, err_idx, chg);
    chk("reset tens only val_valid count", vv_n, 0);
    chk("reset tens only binary", int'(binary), 0);

    run_seg(2'b01, 7'h5B, 6, vv_n, vv_idx, err_n, err_idx, chg);
    chk("reset fresh ones val_valid count", vv_n, 1);
    chk("reset fresh ones latency", vv_idx, 4);
    chk("reset fresh ones changed", chg, 1);
    chk("reset fresh ones binary", int'(binary), 52);
    chk("reset fresh ones one", int'(one), 2);
    chk("reset fresh ones ten", int'(ten), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter STABLE_CYC, default 4: consecutive identical cycles required before a digit is accepted; legal range 2..255.
REQ-002 Parameter SEG_ACTIVE_LOW, default 1: 1 = segment lit when its bit is 0; 0 = lit when 1.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 res  input  1  reset; synchronous and active-high.
REQ-005 digit_seg  input  8  multiplexed display bus; [0]=a .. [6]=g, [7]=dp; dp ignored.
REQ-006 digit_con  input  2  digit select: 2'b01 = ones digit, 2'b10 = tens digit, 2'b00/2'b11 = blank.
REQ-007 one  output  4  last accepted ones digit, BCD.
REQ-008 ten  output  4  last accepted tens digit, BCD.
REQ-009 binary  output  7  ten*10+one, range 0..99.
REQ-010 val_valid  output  1  one-cycle pulse when a new pair is published.
REQ-011 changed  output  1  high with val_valid when binary differs from the previous published value.
REQ-012 err  output  1  one-cycle pulse on an accepted illegal pattern.

Function
REQ-013 Normalise segments first: lit[6:0] = SEG_ACTIVE_LOW ? ~digit_seg[6:0] : digit_seg[6:0].
REQ-014 Legal lit codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex); tens only: 00 (blank) decodes to 0.
REQ-015 Stability counter: increments, saturating at STABLE_CYC, while {digit_con, lit} equals the previous cycle's value; any difference reloads it to 1.
REQ-016 A digit is accepted in the single cycle the counter first reaches STABLE_CYC; a held pattern is never accepted twice.
REQ-017 digit_con blank or 2'b11: counter still runs; acceptance has no effect.
REQ-018 Accepted legal pattern: store BCD in pending ones/tens register, set that digit's captured flag; a re-accept before pairing overwrites.
REQ-019 Accepted illegal pattern (including blank on ones): err pulses next cycle, that digit's captured flag clears, stored outputs unchanged.
REQ-020 FSM states: WAIT_BOTH, PUBLISH; WAIT_BOTH -> PUBLISH when both flags are set; PUBLISH lasts one cycle, then WAIT_BOTH.
REQ-021 In PUBLISH: one, ten, binary update; val_valid=1; changed as REQ-011; both flags clear.
REQ-022 Latency: val_valid asserts exactly 2 cycles after the accept cycle of the second digit.
REQ-023 Acceptance coinciding with PUBLISH is held: its flag remains set after the flag clear.
REQ-024 binary computed as (ten<<3)+(ten<<1)+one in 7 bits; no overflow possible for legal BCD.
REQ-025 The first publish after reset asserts changed unless binary equals 0.

Reset
REQ-026 With res=1 at a rising edge: one=0, ten=0, binary=0, val_valid=0, changed=0, err=0, flags clear, counter=0, previous-sample register=0, FSM=WAIT_BOTH.
REQ-027 Reset mid-operation discards pending digits; no val_valid or err pulse in the cycle after reset deasserts.
REQ-028 The first accept after reset requires a full STABLE_CYC cycles of new samples.

Structure
REQ-029 Package seg7_pkg holds the ten digit lit constants, the blank constant and the FSM state typedef.
REQ-030 Sub-module seg7_to_bcd: combinational lit[6:0] -> {legal, blank, bcd[3:0]}; all state stays in seg_capture.

Verification
REQ-031 Active-low, STABLE_CYC=4: digit_con=01, digit_seg=8'hF9 (1) held 4 cycles; then 10 with 8'hA4 (2) held 4 cycles -> val_valid once, binary=21, ten=2, one=1, changed=1.
REQ-032 Same pair repeated -> val_valid again, binary=21, changed=0.
REQ-033 Ones pattern held only 3 cycles then changed -> no acceptance, no val_valid.
REQ-034 Ones lit=7F held 20 cycles, no tens -> exactly one accept, no val_valid; tens blank (lit 00) for 4 cycles -> binary=8.
REQ-035 Ones lit=49 (illegal) held 4 cycles -> single err pulse, outputs unchanged, ones flag clear.
REQ-036 res pulsed after ones accepted, then tens 5 accepted -> no val_valid until a fresh ones accept; all outputs 0 during and after reset.
